// File: rtl/logic_result_checker_pkg.sv
// -----------------------------------------------------------------------------
// logic_result_checker_pkg
// Shared definitions for the logic-unit result checker and its reference model:
// operation encodings, checker state encoding and the default data width.
// -----------------------------------------------------------------------------
package logic_result_checker_pkg;

  localparam int WIDTH_DEF = 32;

  // Logic-unit operation encodings (2-bit op field)
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  // Checker run-control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/logic_ref_model.sv
// -----------------------------------------------------------------------------
// logic_ref_model
// Combinational golden model of the logic-unit slice. Given an operation and
// two operands it produces the result the slice should have produced.
// Reusable by any checker that monitors the logic unit.
//
// Ports:
//   op       in  2      operation (AND, OR, XOR, NOT a)
//   a, b     in  WIDTH  operands (b ignored for NOT)
//   expected out WIDTH  reference result
// -----------------------------------------------------------------------------
module logic_ref_model
  import logic_result_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = '0;
    case (op_e'(op))
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_NOT:  expected = ~a;
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/logic_result_checker.sv
// -----------------------------------------------------------------------------
// logic_result_checker
// Response monitor for the logic-unit datapath. Accepts EXPECTED_N samples of
// (op, a, b, z) per run, recomputes the expected result, compares it against z
// and keeps saturating pass/fail totals plus a snapshot of the first mismatch.
//
// Ports:
//   clock             in   rising-edge clock
//   clear             in   asynchronous active-high reset
//   start             in   begins a run from IDLE or DONE
//   in_valid          in   sample present on a, b, z, op
//   in_ready          out  checker accepts a sample this cycle
//   op, a, b, z       in   operation, operands and result under test
//   busy              out  run in progress (RUN or DRAIN)
//   done              out  run complete, held until next start or clear
//   pass              out  done with zero failures
//   pass_count        out  saturating count of matching samples
//   fail_count        out  saturating count of mismatching samples
//   first_fail_valid  out  at least one mismatch this run
//   first_fail_idx    out  index of first mismatching sample
//   first_fail_z      out  observed result at first mismatch
//   first_fail_exp    out  expected result at first mismatch
// -----------------------------------------------------------------------------
module logic_result_checker
  import logic_result_checker_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int CNT_W      = 16,
  parameter int EXPECTED_N = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_z,
  output logic [WIDTH-1:0] first_fail_exp
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EXPECTED_N - 1);

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e           state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             start_ok;

  // Stage-1 pipeline register
  logic             vld_p1;
  logic [CNT_W-1:0] idx_p1;
  logic [WIDTH-1:0] z_p1;
  logic [WIDTH-1:0] exp_p1;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  logic_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref_model (
    .op       (op),
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Run control. in_ready/busy/done/pass are registered alongside the state
  // so every output comes straight from a flop.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            idx      <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            idx <= idx + CNT_W'(1);
            if (idx == LAST_IDX) begin
              state    <= ST_DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Wait until the last sample has left stage 1 so the totals seen
          // alongside done are final.
          if (!vld_p1) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == '0);
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage 0 -> stage 1: capture index, observed and expected result ----
  always_ff @(posedge clock or posedge clear) begin
    if (clear) vld_p1 <= 1'b0;
    else       vld_p1 <= accept;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      idx_p1 <= idx;
      z_p1   <= z;
      exp_p1 <= expected;
    end
  end

  // ---- stage 1 -> stage 2: compare and update totals / first mismatch ----
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_z     <= '0;
      first_fail_exp   <= '0;
    end else if (start_ok) begin
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_z     <= '0;
      first_fail_exp   <= '0;
    end else if (vld_p1) begin
      if (z_p1 == exp_p1) begin
        pass_count <= sat_inc(pass_count);
      end else begin
        fail_count <= sat_inc(fail_count);
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= idx_p1;
          first_fail_z     <= z_p1;
          first_fail_exp   <= exp_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_result_checker.sv
module tb_logic_result_checker;
  import logic_result_checker_pkg::*;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int N  = 5;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    int           gap;
  } sample_t;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  z = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] fail_count;
  logic          first_fail_valid;
  logic [CW-1:0] first_fail_idx;
  logic [W-1:0]  first_fail_z;
  logic [W-1:0]  first_fail_exp;

  int total = 0;
  int bad   = 0;

  sample_t run_q[$];

  always #5 clock = ~clock;

  logic_result_checker #(
    .WIDTH      (W),
    .CNT_W      (CW),
    .EXPECTED_N (N)
  ) dut (
    .clock            (clock),
    .clear            (clear),
    .start            (start),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .op               (op),
    .a                (a),
    .b                (b),
    .z                (z),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .first_fail_z     (first_fail_z),
    .first_fail_exp   (first_fail_exp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  function automatic sample_t mk(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [W-1:0] r, input int g);
    sample_t s;
    s.op = o; s.a = x; s.b = y; s.z = r; s.gap = g;
    return s;
  endfunction

  function automatic sample_t rand_sample();
    sample_t s;
    s.op  = 2'($urandom_range(0, 3));
    s.a   = $urandom;
    s.b   = $urandom;
    s.z   = ref_result(s.op, s.a, s.b);
    if ($urandom_range(0, 3) == 0) s.z = s.z ^ (32'h1 << $urandom_range(0, 31));
    s.gap = $urandom_range(0, 2);
    return s;
  endfunction

  // Called right after a negedge; leaves right after a later negedge.
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic feed(input string tag, input sample_t s);
    in_valid = 1'b0;
    repeat (s.gap) begin
      a = $urandom; b = $urandom; z = $urandom;
      @(negedge clock);
    end
    in_valid = 1'b1;
    op = s.op; a = s.a; b = s.b; z = s.z;
    check({tag, ".in_ready_run"}, 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    run_q.push_back(s);
  endtask

  task automatic zero_outputs_check(input string tag);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".pass"}, 64'(pass), 64'd0);
    check({tag, ".pass_count"}, 64'(pass_count), 64'd0);
    check({tag, ".fail_count"}, 64'(fail_count), 64'd0);
    check({tag, ".ff_valid"}, 64'(first_fail_valid), 64'd0);
    check({tag, ".ff_idx"}, 64'(first_fail_idx), 64'd0);
    check({tag, ".ff_z"}, 64'(first_fail_z), 64'd0);
    check({tag, ".ff_exp"}, 64'(first_fail_exp), 64'd0);
  endtask

  // Entered half a cycle after the final accept; checks the two-cycle
  // completion latency, then the totals against the reference model.
  task automatic finish_run(input string tag);
    int          n_pass = 0;
    int          n_fail = 0;
    logic        ff_v   = 1'b0;
    int          ff_i   = 0;
    logic [W-1:0] ff_z  = '0;
    logic [W-1:0] ff_e  = '0;
    check({tag, ".in_ready_drain"}, 64'(in_ready), 64'd0);
    check({tag, ".busy_k"}, 64'(busy), 64'd1);
    check({tag, ".done_k"}, 64'(done), 64'd0);
    @(negedge clock);
    check({tag, ".done_k1"}, 64'(done), 64'd0);
    check({tag, ".busy_k1"}, 64'(busy), 64'd1);
    @(negedge clock);
    check({tag, ".done_k2"}, 64'(done), 64'd1);
    check({tag, ".busy_k2"}, 64'(busy), 64'd0);
    for (int i = 0; i < run_q.size(); i++) begin
      logic [W-1:0] e;
      e = ref_result(run_q[i].op, run_q[i].a, run_q[i].b);
      if (run_q[i].z == e) n_pass++;
      else begin
        n_fail++;
        if (!ff_v) begin
          ff_v = 1'b1; ff_i = i; ff_z = run_q[i].z; ff_e = e;
        end
      end
    end
    check({tag, ".pass"}, 64'(pass), 64'(n_fail == 0));
    check({tag, ".pass_count"}, 64'(pass_count), 64'(n_pass));
    check({tag, ".fail_count"}, 64'(fail_count), 64'(n_fail));
    check({tag, ".ff_valid"}, 64'(first_fail_valid), 64'(ff_v));
    check({tag, ".ff_idx"}, 64'(first_fail_idx), 64'(ff_i));
    check({tag, ".ff_z"}, 64'(first_fail_z), 64'(ff_z));
    check({tag, ".ff_exp"}, 64'(first_fail_exp), 64'(ff_e));
    run_q.delete();
  endtask

  task automatic start_run(input string tag);
    run_q.delete();
    pulse_start();
    check({tag, ".start_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".start_busy"}, 64'(busy), 64'd1);
  endtask

  sample_t and_vec[5];

  initial begin
    and_vec[0] = mk(OP_AND, 32'h0,        32'h0,        32'h0,        0);
    and_vec[1] = mk(OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    and_vec[2] = mk(OP_AND, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFC, 0);
    and_vec[3] = mk(OP_AND, 32'hF,        32'hF,        32'hF,        0);
    and_vec[4] = mk(OP_AND, 32'h1,        32'h1,        32'h1,        0);

    // Reset state
    repeat (2) @(negedge clock);
    zero_outputs_check("reset");
    clear = 1'b0;

    // in_valid while IDLE must not be consumed
    in_valid = 1'b1; op = OP_AND; a = 32'h3; b = 32'h3; z = 32'h0;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    check("idle_valid.in_ready", 64'(in_ready), 64'd0);
    check("idle_valid.busy", 64'(busy), 64'd0);
    check("idle_valid.fail_count", 64'(fail_count), 64'd0);

    // All-pass AND run, back to back
    start_run("and_pass");
    for (int i = 0; i < N; i++) feed("and_pass", and_vec[i]);
    finish_run("and_pass");

    // Injected failure on sample 2
    start_run("inject");
    for (int i = 0; i < N; i++) begin
      sample_t s;
      s = and_vec[i];
      if (i == 2) s.z = 32'hFFFFFFFD;
      feed("inject", s);
    end
    check("inject.ref_idx2", 64'(ref_result(OP_AND, 32'hFFFFFFFC, 32'hFFFFFFFD)), 64'hFFFFFFFC);
    finish_run("inject");

    // Failures on samples 1 and 3; first one must be retained
    start_run("multi");
    for (int i = 0; i < N; i++) begin
      sample_t s;
      s = and_vec[i];
      if (i == 1) s.z = 32'h0;
      if (i == 3) s.z = 32'hE;
      feed("multi", s);
    end
    finish_run("multi");

    // start from DONE wipes the previous run's results
    start_run("restart");
    check("restart.fail_count", 64'(fail_count), 64'd0);
    check("restart.pass_count", 64'(pass_count), 64'd0);
    check("restart.ff_valid", 64'(first_fail_valid), 64'd0);
    check("restart.ff_idx", 64'(first_fail_idx), 64'd0);
    check("restart.done", 64'(done), 64'd0);

    // Mixed ops with gaps, then start during RUN, then finish the run
    feed("mixed", mk(OP_OR,  32'hF0, 32'h0F, 32'hFF, 2));
    feed("mixed", mk(OP_XOR, 32'hFF, 32'h0F, 32'hF0, 3));
    feed("mixed", mk(OP_NOT, 32'h0, $urandom, 32'hFFFFFFFF, 1));
    @(negedge clock);
    check("mixed.pass_count3", 64'(pass_count), 64'd3);
    check("mixed.fail_count3", 64'(fail_count), 64'd0);
    pulse_start();
    check("start_in_run.busy", 64'(busy), 64'd1);
    check("start_in_run.in_ready", 64'(in_ready), 64'd1);
    check("start_in_run.pass_count", 64'(pass_count), 64'd3);
    feed("mixed", mk(OP_OR, 32'h1, 32'h2, 32'h3, 0));
    feed("mixed", mk(OP_AND, 32'h6, 32'h3, 32'h2, 1));
    finish_run("mixed");

    // clear mid-run after two samples
    start_run("clr");
    feed("clr", and_vec[0]);
    feed("clr", and_vec[1]);
    @(negedge clock);
    check("clr.pre_pass_count", 64'(pass_count), 64'd2);
    clear = 1'b1;
    #1;
    zero_outputs_check("clr_async");
    @(negedge clock);
    clear = 1'b0;
    start_run("after_clr");
    for (int i = 0; i < N; i++) feed("after_clr", and_vec[i]);
    finish_run("after_clr");

    // Randomized runs with occasional corrupted results and idle gaps
    for (int r = 0; r < 8; r++) begin
      start_run("rand");
      for (int i = 0; i < N; i++) feed("rand", rand_sample());
      finish_run("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
